// File: rtl/process_scheduler_pkg.sv
// Shared scheduler types and the address constants that must stay aligned with program_counter.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEARCH   = 2'd1,
        DISPATCH = 2'd2
    } sched_state_t;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned BASE_OFFSET = 200;

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/process_scheduler_if.sv
// OS/PC-facing signal bundle of the scheduler; master is the OS side, slave is the scheduler.
interface process_scheduler_if #(
    parameter int unsigned NUM_PROGS = 8,
    parameter int unsigned ADDR_W    = proc_pkg::ADDR_W
);
    import proc_pkg::*;

    localparam int unsigned SW = slot_w(NUM_PROGS);

    logic              create_en;
    logic [SW-1:0]     create_slot;
    logic [ADDR_W-1:0] create_pc;
    logic              save_en;
    logic [ADDR_W-1:0] save_pc;
    logic              prog_done;
    logic              dispatch_req;
    logic              lpc;
    logic [ADDR_W-1:0] enderecoPc;
    logic [SW-1:0]     cur_prog;
    logic              busy;
    logic              none_ready;
    logic              create_err;

    modport master (
        output create_en, create_slot, create_pc, save_en, save_pc, prog_done, dispatch_req,
        input  lpc, enderecoPc, cur_prog, busy, none_ready, create_err
    );

    modport slave (
        input  create_en, create_slot, create_pc, save_en, save_pc, prog_done, dispatch_req,
        output lpc, enderecoPc, cur_prog, busy, none_ready, create_err
    );

endinterface

// File: rtl/process_scheduler_context_table.sv
// Per-slot {valid, rel_pc} register file: create and save write ports, one combinational read.
module context_table #(
    parameter int unsigned NUM_PROGS = 8,
    parameter int unsigned ADDR_W    = proc_pkg::ADDR_W,
    localparam int unsigned SW       = proc_pkg::slot_w(NUM_PROGS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cw_en_i,
    input  logic [SW-1:0]     cw_slot_i,
    input  logic [ADDR_W-1:0] cw_pc_i,
    input  logic              sw_en_i,
    input  logic [SW-1:0]     sw_slot_i,
    input  logic              sw_valid_i,
    input  logic [ADDR_W-1:0] sw_pc_i,
    input  logic [SW-1:0]     rd_idx_i,
    output logic              rd_valid_o,
    output logic [ADDR_W-1:0] rd_pc_o
);
    import proc_pkg::*;

    logic [NUM_PROGS-1:0] valid_q;
    logic [ADDR_W-1:0]    pc_q [NUM_PROGS];

    // Slot 0 belongs to the OS and is never written, so it stays invalid forever.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < NUM_PROGS; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_PROGS; i++) begin
                if (cw_en_i && (cw_slot_i == SW'(i))) begin
                    valid_q[i] <= 1'b1;
                    pc_q[i]    <= cw_pc_i;
                end else if (sw_en_i && (sw_slot_i == SW'(i))) begin
                    valid_q[i] <= sw_valid_i;
                    pc_q[i]    <= sw_pc_i;
                end
            end
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_pc_o    = pc_q[rd_idx_i];

endmodule

// File: rtl/process_scheduler.sv
// Round-robin context scheduler feeding program_counter: saves trapped PCs, picks the next ready slot.
module process_scheduler #(
    parameter int unsigned NUM_PROGS   = 8,
    parameter int unsigned ADDR_W      = proc_pkg::ADDR_W,
    parameter int unsigned BASE_OFFSET = proc_pkg::BASE_OFFSET
) (
    input logic               clock,
    input logic               reset,
    process_scheduler_if.slave bus
);
    import proc_pkg::*;

    localparam int unsigned SW = slot_w(NUM_PROGS);

    sched_state_t      state_q, state_d;
    logic [SW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     cur_q, cur_d;
    logic              pending_q, pending_d;
    logic              lpc_q, lpc_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              none_q, none_d;
    logic              cerr_q, cerr_d;

    logic              cw_en;
    logic              sw_en;
    logic              sw_valid;
    logic [ADDR_W-1:0] sw_pc;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_pc;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
        return (i == SW'(NUM_PROGS - 1)) ? SW'(1) : i + SW'(1);
    endfunction

    context_table #(
        .NUM_PROGS(NUM_PROGS),
        .ADDR_W   (ADDR_W)
    ) u_table (
        .clk_i     (clock),
        .rst_n_i   (reset),
        .cw_en_i   (cw_en),
        .cw_slot_i (bus.create_slot),
        .cw_pc_i   (bus.create_pc),
        .sw_en_i   (sw_en),
        .sw_slot_i (cur_q),
        .sw_valid_i(sw_valid),
        .sw_pc_i   (sw_pc),
        .rd_idx_i  (idx_q),
        .rd_valid_o(rd_valid),
        .rd_pc_o   (rd_pc)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        pending_d = pending_q;
        lpc_d     = 1'b0;
        pc_d      = pc_q;
        none_d    = 1'b0;
        sw_en     = 1'b0;
        sw_valid  = 1'b0;
        sw_pc     = bus.save_pc - (ADDR_W'(cur_q) * ADDR_W'(BASE_OFFSET));
        cerr_d    = bus.create_en &&
                    ((bus.create_slot == '0) || (32'(bus.create_slot) >= NUM_PROGS));
        cw_en     = bus.create_en && !cerr_d;

        unique case (state_q)
            IDLE: begin
                // A save takes this cycle; any dispatch request is deferred one cycle via pending.
                if (bus.save_en && (cur_q != '0)) begin
                    sw_en    = 1'b1;
                    sw_valid = !bus.prog_done;
                    cur_d    = '0;
                    if (bus.dispatch_req || pending_q) begin
                        pending_d = 1'b1;
                    end
                end else if (bus.dispatch_req || pending_q) begin
                    state_d   = SEARCH;
                    idx_d     = next_idx(cur_q);
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            SEARCH: begin
                if (bus.dispatch_req) begin
                    pending_d = 1'b1;
                end
                if (rd_valid) begin
                    state_d = DISPATCH;
                    lpc_d   = 1'b1;
                    pc_d    = rd_pc;
                    cur_d   = idx_q;
                end else if (cnt_q == SW'(NUM_PROGS - 2)) begin
                    state_d = IDLE;
                    none_d  = 1'b1;
                    cur_d   = '0;
                end else begin
                    idx_d = next_idx(idx_q);
                    cnt_d = cnt_q + SW'(1);
                end
            end
            DISPATCH: begin
                if (bus.dispatch_req) begin
                    pending_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            cur_q     <= '0;
            pending_q <= 1'b0;
            lpc_q     <= 1'b0;
            pc_q      <= '0;
            none_q    <= 1'b0;
            cerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            pending_q <= pending_d;
            lpc_q     <= lpc_d;
            pc_q      <= pc_d;
            none_q    <= none_d;
            cerr_q    <= cerr_d;
        end
    end

    assign bus.lpc        = lpc_q;
    assign bus.enderecoPc = pc_q;
    assign bus.cur_prog   = cur_q;
    assign bus.busy       = (state_q != IDLE) || pending_q;
    assign bus.none_ready = none_q;
    assign bus.create_err = cerr_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler with NUM_PROGS=8, BASE_OFFSET=200.
module tb_process_scheduler;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    process_scheduler_if #(.NUM_PROGS(8), .ADDR_W(32)) bus ();

    process_scheduler #(
        .NUM_PROGS  (8),
        .ADDR_W     (32),
        .BASE_OFFSET(200)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic create(input logic [2:0] slot, input logic [31:0] pc);
        bus.create_en   = 1'b1;
        bus.create_slot = slot;
        bus.create_pc   = pc;
        @(negedge clk);
        bus.create_en   = 1'b0;
    endtask

    task automatic save(input logic [31:0] spc, input logic done);
        bus.save_en   = 1'b1;
        bus.save_pc   = spc;
        bus.prog_done = done;
        @(negedge clk);
        bus.save_en   = 1'b0;
        bus.prog_done = 1'b0;
    endtask

    // Cycle count n is measured in negedges after the request was presented.
    task automatic run_dispatch(input logic do_save, input logic done, input logic [31:0] spc,
                                input int max_cyc, output int n, output logic saw_lpc,
                                output logic saw_none, output logic busy1,
                                output logic [31:0] pc_seen, output logic [2:0] cur_seen);
        bus.dispatch_req = 1'b1;
        bus.save_en      = do_save;
        bus.prog_done    = done;
        bus.save_pc      = spc;
        n = 0; saw_lpc = 1'b0; saw_none = 1'b0; busy1 = 1'b0; pc_seen = '0; cur_seen = '0;
        while (n < max_cyc && !saw_lpc && !saw_none) begin
            @(negedge clk);
            bus.dispatch_req = 1'b0;
            bus.save_en      = 1'b0;
            bus.prog_done    = 1'b0;
            n++;
            if (n == 1) busy1 = bus.busy;
            if (bus.lpc === 1'b1) begin
                saw_lpc  = 1'b1;
                pc_seen  = bus.enderecoPc;
                cur_seen = bus.cur_prog;
            end
            if (bus.none_ready === 1'b1) begin
                saw_none = 1'b1;
                cur_seen = bus.cur_prog;
            end
        end
    endtask

    initial begin
        int          n;
        logic        sl, sn, b1, saw;
        logic [31:0] pc;
        logic [2:0]  cur;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.create_en = 1'b0; bus.create_slot = '0; bus.create_pc = '0;
        bus.save_en = 1'b0; bus.save_pc = '0; bus.prog_done = 1'b0; bus.dispatch_req = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_lpc", bus.lpc, 0);
        check("rst_pc", bus.enderecoPc, 0);
        check("rst_cur", bus.cur_prog, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_none", bus.none_ready, 0);
        check("rst_cerr", bus.create_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        create(3'd1, 32'd0);
        create(3'd2, 32'd5);
        check("create_ok_no_err", bus.create_err, 0);

        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d1_lpc", sl, 1); check("d1_lat", n, 2); check("d1_busy", b1, 1);
        check("d1_pc", pc, 0); check("d1_cur", cur, 1);
        @(negedge clk);
        check("d1_lpc_drop", bus.lpc, 0);
        check("d1_idle", bus.busy, 0);

        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d2_lpc", sl, 1); check("d2_lat", n, 2);
        check("d2_pc", pc, 5); check("d2_cur", cur, 2);
        @(negedge clk);

        save(32'd417, 1'b0);
        check("save_cur0", bus.cur_prog, 0);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d3_cur", cur, 1); check("d3_pc", pc, 0);
        @(negedge clk);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d4_cur", cur, 2); check("d4_relpc", pc, 17);
        @(negedge clk);
        check("d4_hold_pc", bus.enderecoPc, 17);

        save(32'd404, 1'b1);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d5_cur", cur, 1);
        @(negedge clk);
        save(32'd200, 1'b1);
        create(3'd3, 32'd9);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d6_lat", n, 4); check("d6_cur", cur, 3); check("d6_pc", pc, 9);
        @(negedge clk);

        save(32'd601, 1'b1);
        run_dispatch(1'b0, 1'b0, 32'd0, 20, n, sl, sn, b1, pc, cur);
        check("d7_none", sn, 1); check("d7_nolpc", sl, 0);
        check("d7_lat", n, 8); check("d7_cur", cur, 0);
        @(negedge clk);
        check("d7_none_pulse", bus.none_ready, 0);
        check("d7_idle", bus.busy, 0);

        create(3'd6, 32'd60);
        create(3'd7, 32'd70);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d8_lat", n, 7); check("d8_cur", cur, 6); check("d8_pc", pc, 60);
        @(negedge clk);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("d9_lat", n, 2); check("d9_cur", cur, 7); check("d9_pc", pc, 70);
        @(negedge clk);
        run_dispatch(1'b0, 1'b0, 32'd0, 16, n, sl, sn, b1, pc, cur);
        check("wrap_lat", n, 7); check("wrap_cur", cur, 6); check("wrap_pc", pc, 60);
        @(negedge clk);

        bus.create_en = 1'b1; bus.create_slot = 3'd0; bus.create_pc = 32'd123;
        @(negedge clk);
        bus.create_en = 1'b0;
        check("cerr_pulse", bus.create_err, 1);
        @(negedge clk);
        check("cerr_clear", bus.create_err, 0);

        run_dispatch(1'b1, 1'b0, 32'd1233, 20, n, sl, sn, b1, pc, cur);
        check("sd_busy", b1, 1); check("sd_lpc", sl, 1); check("sd_lat", n, 8);
        check("sd_cur", cur, 6); check("sd_pc", pc, 33);
        @(negedge clk);

        save(32'd1200, 1'b1);
        bus.dispatch_req = 1'b1;
        @(negedge clk);
        bus.dispatch_req = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_lpc", bus.lpc, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cur", bus.cur_prog, 0);
        check("mid_rst_pc", bus.enderecoPc, 0);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.lpc !== 1'b0) saw = 1'b1;
        end
        check("mid_rst_nolpc", saw, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_dispatch(1'b0, 1'b0, 32'd0, 20, n, sl, sn, b1, pc, cur);
        check("post_rst_none", sn, 1); check("post_rst_nolpc", sl, 0);
        check("post_rst_lat", n, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
